// File: rtl/i2cmb_wb_sequencer.sv
// i2cmb_wb_sequencer: Wishbone master that drives iicmb_m_wb through complete single-byte I2C transfers
// Ports: clk_i/rst_i (sync, active-high); req_* request in, req_ready while idle;
//        rsp_valid pulse with rsp_data/rsp_status; cyc_o/stb_o/we_o/adr_o/dat_o/dat_i/ack_i Wishbone master; irq_i DUT interrupt.
// Build option: I2CMB_SEQ_IRQ_EN enables the CSR interrupt and makes WAIT read CMDR only after irq_i.
module i2cmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int NUM_I2C_BUSSES = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [3:0]               req_bus,
    input  logic [6:0]               req_addr,
    input  logic [7:0]               req_data,
    output logic                     rsp_valid,
    output logic [7:0]               rsp_data,
    output logic [1:0]               rsp_status,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);
    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_SB_DPR, S_SB_CMD, S_START, S_AD_DPR, S_AD_CMD,
        S_DT_DPR, S_DT_CMD, S_RDDPR, S_STOP, S_WAIT, S_RESP
    } state_t;
    typedef enum logic [2:0] {P_SETBUS, P_START, P_ADDR, P_DATA, P_STOP} phase_t;

    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);
`ifdef I2CMB_SEQ_IRQ_EN
    localparam logic [7:0] CSR_VAL = 8'hC0;
`else
    localparam logic [7:0] CSR_VAL = 8'h80;
    logic unused_irq;
    assign unused_irq = irq_i;
`endif

    state_t                   state_q, state_d, nxt;
    phase_t                   phase_q, phase_d;
    logic                     cyc_q, cyc_d, stb_q, stb_d, wb_we_q, wb_we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d, acc_adr;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d, acc_dat;
    logic                     acc, acc_we;
    logic                     r_we_q, r_we_d;
    logic [3:0]               r_bus_q, r_bus_d, cb_q, cb_d;
    logic [6:0]               r_addr_q, r_addr_d;
    logic [7:0]               r_data_q, r_data_d, rd_q, rd_d;
    logic [1:0]               st_q, st_d;
    logic                     cv_q, cv_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [7:0]               rsp_data_q, rsp_data_d;
    logic [1:0]               rsp_status_q, rsp_status_d;
    logic                     bad_bus;

    assign bad_bus = 32'(req_bus) >= 32'(NUM_I2C_BUSSES);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        wb_we_d  = wb_we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        r_we_d   = r_we_q;
        r_bus_d  = r_bus_q;
        r_addr_d = r_addr_q;
        r_data_d = r_data_q;
        rd_d     = rd_q;
        st_d     = st_q;
        cv_d     = cv_q;
        cb_d     = cb_q;
        acc      = 1'b0;
        acc_adr  = A_CMDR;
        acc_we   = 1'b1;
        acc_dat  = '0;
        nxt      = state_q;
        case (state_q)
            S_INIT: begin
                acc     = 1'b1;
                acc_adr = A_CSR;
                acc_dat = WB_DATA_WIDTH'(CSR_VAL);
                nxt     = S_IDLE;
            end
            S_IDLE: if (req_valid) begin
                r_we_d   = req_we;
                r_bus_d  = req_bus;
                r_addr_d = req_addr;
                r_data_d = req_data;
                rd_d     = 8'h00;
                st_d     = bad_bus ? 2'b11 : 2'b00;
                state_d  = bad_bus ? S_RESP : (cv_q && cb_q == req_bus) ? S_START : S_SB_DPR;
            end
            S_SB_DPR: begin
                acc     = 1'b1;
                acc_adr = A_DPR;
                acc_dat = WB_DATA_WIDTH'(r_bus_q);
                nxt     = S_SB_CMD;
            end
            S_SB_CMD: begin
                acc     = 1'b1;
                acc_dat = WB_DATA_WIDTH'(8'h06);
                phase_d = P_SETBUS;
                nxt     = S_WAIT;
            end
            S_START: begin
                acc     = 1'b1;
                acc_dat = WB_DATA_WIDTH'(8'h04);
                phase_d = P_START;
                nxt     = S_WAIT;
            end
            S_AD_DPR: begin
                acc     = 1'b1;
                acc_adr = A_DPR;
                acc_dat = WB_DATA_WIDTH'({r_addr_q, ~r_we_q});
                nxt     = S_AD_CMD;
            end
            S_AD_CMD: begin
                acc     = 1'b1;
                acc_dat = WB_DATA_WIDTH'(8'h01);
                phase_d = P_ADDR;
                nxt     = S_WAIT;
            end
            S_DT_DPR: begin
                acc     = 1'b1;
                acc_adr = A_DPR;
                acc_dat = WB_DATA_WIDTH'(r_data_q);
                nxt     = S_DT_CMD;
            end
            S_DT_CMD: begin
                acc     = 1'b1;
                acc_dat = WB_DATA_WIDTH'(r_we_q ? 8'h01 : 8'h03);
                phase_d = P_DATA;
                nxt     = S_WAIT;
            end
            S_RDDPR: begin
                acc     = 1'b1;
                acc_adr = A_DPR;
                acc_we  = 1'b0;
                nxt     = S_STOP;
            end
            S_STOP: begin
                acc     = 1'b1;
                acc_dat = WB_DATA_WIDTH'(8'h05);
                phase_d = P_STOP;
                nxt     = S_WAIT;
            end
            S_WAIT: begin
`ifdef I2CMB_SEQ_IRQ_EN
                acc    = cyc_q || irq_i;
`else
                acc    = 1'b1;
`endif
                acc_we = 1'b0;
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
        // Launch an access when the bus is idle, hold it until ack, then drop everything for one cycle.
        if (acc && !cyc_q) begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            wb_we_d = acc_we;
            adr_d   = acc_adr;
            dat_d   = acc_dat;
        end else if (acc && ack_i) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            wb_we_d = 1'b0;
            adr_d   = '0;
            dat_d   = '0;
            state_d = nxt;
        end
        if (state_q == S_RDDPR && cyc_q && ack_i)
            rd_d = dat_i[7:0];
        // CMDR status: AL > ERR > NAK > DON; an all-clear read keeps polling.
        if (state_q == S_WAIT && cyc_q && ack_i) begin
            if (dat_i[5]) begin
                st_d    = 2'b10;
                cv_d    = 1'b0;
                state_d = S_RESP;
            end else if (dat_i[4] || dat_i[6]) begin
                st_d    = dat_i[4] ? 2'b11 : 2'b01;
                cv_d    = dat_i[4] ? 1'b0 : cv_q;
                state_d = phase_q == P_STOP ? S_RESP : S_STOP;
            end else if (dat_i[7]) begin
                cv_d    = phase_q == P_SETBUS ? 1'b1 : cv_q;
                cb_d    = phase_q == P_SETBUS ? r_bus_q : cb_q;
                state_d = phase_q == P_SETBUS ? S_START :
                          phase_q == P_START  ? S_AD_DPR :
                          phase_q == P_ADDR   ? (r_we_q ? S_DT_DPR : S_DT_CMD) :
                          phase_q == P_DATA   ? (r_we_q ? S_STOP : S_RDDPR) : S_RESP;
            end
        end
        rsp_valid_d  = state_d == S_RESP;
        rsp_status_d = state_d == S_RESP ? st_d : rsp_status_q;
        rsp_data_d   = state_d == S_RESP ? (r_we_d ? 8'h00 : rd_d) : rsp_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_INIT;
            phase_q      <= P_SETBUS;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            wb_we_q      <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            r_we_q       <= 1'b0;
            r_bus_q      <= 4'd0;
            r_addr_q     <= 7'd0;
            r_data_q     <= 8'd0;
            rd_q         <= 8'd0;
            st_q         <= 2'b00;
            cv_q         <= 1'b0;
            cb_q         <= 4'd0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 8'd0;
            rsp_status_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            wb_we_q      <= wb_we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            r_we_q       <= r_we_d;
            r_bus_q      <= r_bus_d;
            r_addr_q     <= r_addr_d;
            r_data_q     <= r_data_d;
            rd_q         <= rd_d;
            st_q         <= st_d;
            cv_q         <= cv_d;
            cb_q         <= cb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req_ready  = state_q == S_IDLE;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign cyc_o      = cyc_q;
    assign stb_o      = stb_q;
    assign we_o       = wb_we_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// tb_i2cmb_wb_sequencer: randomized bench with a behavioural iicmb slave and a transfer-level reference model
module tb_i2cmb_wb_sequencer;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid, req_ready, req_we;
    logic [3:0] req_bus;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_status;
    logic       cyc_o, stb_o, we_o, ack_i, irq_i;
    logic [1:0] adr_o;
    logic [7:0] dat_o, dat_i;

`ifdef I2CMB_SEQ_IRQ_EN
    localparam logic [7:0] CSR_EXP = 8'hC0;
`else
    localparam logic [7:0] CSR_EXP = 8'h80;
`endif

    always #5 clk = ~clk;

    i2cmb_wb_sequencer dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_bus(req_bus), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input bit w, input int a, input int d);
        return {w, 2'(a), 8'(d)};
    endfunction

    // Behavioural iicmb slave: access log of every write and every DPR read, delayed command completion.
    logic [10:0] wlog[$];
    logic [10:0] cur, prev_acc;
    bit          stall = 0, pend, rdy, after_start, inflight;
    int          busy, lat, scen = 0, proto_err = 0;
    logic [7:0]  stat_val, rdata = 8'h00;

    initial begin
        ack_i = 0; dat_i = 0; irq_i = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                ack_i = 0; irq_i = 0; pend = 0; rdy = 0; after_start = 0; inflight = 0;
                continue;
            end
            cur = {we_o, adr_o, dat_o};
            if (cyc_o !== stb_o) proto_err++;
            if (ack_i) begin
                ack_i = 0;
                inflight = 0;
                if (cyc_o || stb_o) proto_err++;
            end else if (cyc_o && stb_o) begin
                if (inflight && cur !== prev_acc) proto_err++;
                if (!inflight) begin
                    inflight = 1;
                    prev_acc = cur;
                    lat = $urandom_range(0, 3);
                end
                if (!stall && lat == 0) begin
                    ack_i = 1;
                    if (we_o) begin
                        wlog.push_back(cur);
                        if (adr_o == 2'd2) begin
                            pend = 1; rdy = 0; irq_i = 0;
                            busy = $urandom_range(0, 5);
                            stat_val = 8'h80;
                            if (dat_o == 8'h04) after_start = 1;
                            else if (dat_o == 8'h01 && after_start) begin
                                after_start = 0;
                                stat_val = scen == 1 ? 8'h40 : scen == 2 ? 8'h20 : scen == 3 ? 8'h10 : 8'h80;
                            end
                        end
                    end else if (adr_o == 2'd2) begin
                        dat_i = rdy ? stat_val : 8'h00;
                        if (rdy) begin rdy = 0; irq_i = 0; end
                    end else begin
                        dat_i = adr_o == 2'd1 ? rdata : 8'h00;
                        if (adr_o == 2'd1) wlog.push_back({1'b0, 2'd1, rdata});
                    end
                end else if (!stall) lat--;
            end else if (inflight) proto_err++;
            if (pend) begin
                if (busy == 0) begin pend = 0; rdy = 1; irq_i = 1; end
                else busy--;
            end
        end
    end

    // Reference model: expected access list and response computed from the transfer rules.
    logic [10:0] exp_q[$];
    bit          m_cv = 0;
    logic [3:0]  m_cb = 0;

    task automatic build_exp(input bit we, input logic [3:0] bus, input logic [6:0] addr,
                             input logic [7:0] data, input int sc, input logic [7:0] rd,
                             output logic [1:0] est, output logic [7:0] edat);
        exp_q.delete();
        edat = 8'h00;
        est = 2'b11;
        if (bus < 1) begin
            if (!(m_cv && m_cb == bus)) begin
                exp_q.push_back(mk(1, 1, bus));
                exp_q.push_back(mk(1, 2, 8'h06));
            end
            m_cv = 1; m_cb = bus;
            exp_q.push_back(mk(1, 2, 8'h04));
            exp_q.push_back(mk(1, 1, {addr, ~we}));
            exp_q.push_back(mk(1, 2, 8'h01));
            if (sc == 2) begin
                est = 2'b10; m_cv = 0;
            end else begin
                if (sc == 0 && we) begin
                    exp_q.push_back(mk(1, 1, data));
                    exp_q.push_back(mk(1, 2, 8'h01));
                end else if (sc == 0) begin
                    exp_q.push_back(mk(1, 2, 8'h03));
                    exp_q.push_back(mk(0, 1, rd));
                    edat = rd;
                end
                exp_q.push_back(mk(1, 2, 8'h05));
                est = sc == 1 ? 2'b01 : sc == 3 ? 2'b11 : 2'b00;
                if (sc == 3) m_cv = 0;
            end
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 500) begin @(negedge clk); n++; end
        chk(tag, n < 500, 1);
    endtask

    task automatic run_req(input bit we, input logic [3:0] bus, input logic [6:0] addr,
                           input logic [7:0] data, input int sc, input logic [7:0] rd);
        logic [1:0] est;
        logic [7:0] edat;
        int n;
        build_exp(we, bus, addr, data, sc, rd, est, edat);
        scen = sc; rdata = rd;
        @(negedge clk);
        wlog.delete();
        req_valid = 1; req_we = we; req_bus = bus; req_addr = addr; req_data = data;
        wait_ready("ready_wait");
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 5000) begin @(negedge clk); n++; end
        chk("rsp_wait", n < 5000, 1);
        if (bus >= 1) chk("badbus_lat", n, 0);
        chk("status", rsp_status, est);
        chk("rdata", rsp_data, edat);
        chk("n_acc", wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) chk("acc", wlog[i], exp_q[i]);
        @(negedge clk);
        chk("pulse", rsp_valid, 0);
        chk("hold", rsp_status, est);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, sc;
        req_valid = 0; req_we = 0; req_bus = 0; req_addr = 0; req_data = 0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_adr", adr_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rspd", rsp_data, 0);
        chk("rst_rsps", rsp_status, 0);
        wlog.delete();
        rst_i = 0;
        wait_ready("init_wait");
        chk("init_n", wlog.size(), 1);
        for (int i = 0; i < wlog.size(); i++) chk("init_csr", wlog[i], mk(1, 0, CSR_EXP));

        run_req(1, 0, 7'h22, 8'h5A, 0, 8'h00);
        run_req(0, 0, 7'h22, 8'h00, 0, 8'hA5);
        run_req(1, 0, 7'h11, 8'h33, 1, 8'h00);
        run_req(0, 0, 7'h11, 8'h00, 1, 8'h77);
        run_req(1, 0, 7'h22, 8'h44, 2, 8'h00);
        run_req(1, 0, 7'h22, 8'h44, 0, 8'h00);
        run_req(1, 1, 7'h22, 8'h44, 0, 8'h00);
        run_req(0, 0, 7'h35, 8'h00, 3, 8'h12);
        run_req(0, 0, 7'h35, 8'h00, 0, 8'hC3);
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 9);
            sc = n < 6 ? 0 : n - 6;
            run_req(1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0 ? 4'($urandom_range(1, 15)) : 4'd0,
                    7'($urandom), 8'($urandom), sc, 8'($urandom));
        end

        stall = 1;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_bus = 0; req_addr = 7'h22; req_data = 8'h99;
        n = 0;
        while (!cyc_o && n < 500) begin @(negedge clk); n++; end
        chk("stall_wait", n < 500, 1);
        rst_i = 1;
        @(negedge clk);
        chk("mid_rst_cyc", cyc_o, 0);
        chk("mid_rst_stb", stb_o, 0);
        chk("mid_rst_ready", req_ready, 0);
        req_valid = 0; stall = 0; m_cv = 0;
        @(negedge clk);
        wlog.delete();
        rst_i = 0;
        wait_ready("reinit_wait");
        chk("reinit_n", wlog.size(), 1);
        for (int i = 0; i < wlog.size(); i++) chk("reinit_csr", wlog[i], mk(1, 0, CSR_EXP));
        run_req(0, 0, 7'h22, 8'h00, 0, 8'h5C);

        chk("protocol", proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2cmb_wb_sequencer.md
# i2cmb_wb_sequencer

Wishbone master that sequences the I2C multi-bus controller (iicmb_m_wb) through complete single-byte I2C transfers. It accepts one request at a time (bus, 7-bit address, read/write, data) and issues the CSR/DPR/CMDR register accesses for each transfer: enable, set bus, start, address, data, stop. It collects completion status and returns read data. It sits between a local requester and the DUT's Wishbone slave port, sharing `clk_i`/`rst_i` with it.

## Interface
- `WB_ADDR_WIDTH`, 2, Wishbone address width (register select).
- `WB_DATA_WIDTH`, 8, Wishbone data width.
- `NUM_I2C_BUSSES`, 1, number of DUT busses; requests with `req_bus >= NUM_I2C_BUSSES` are rejected.
- `clk_i` in 1: single clock, shared with the DUT.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_we` in 1: 1 = I2C write, 0 = I2C read.
- `req_bus` in 4: target I2C bus index.
- `req_addr` in 7: I2C slave address.
- `req_data` in 8: write data.
- `rsp_valid` out 1: one-cycle pulse when the transfer completes.
- `rsp_data` out 8: read data (0x00 for writes).
- `rsp_status` out 2: 00 OK, 01 NAK, 10 arbitration lost, 11 error/bad bus.
- `cyc_o`, `stb_o`, `we_o` out 1 each: Wishbone master controls.
- `adr_o` out `WB_ADDR_WIDTH`: 0 = CSR, 1 = DPR, 2 = CMDR, 3 = FSMR.
- `dat_o` out `WB_DATA_WIDTH`, `dat_i` in `WB_DATA_WIDTH`: write and read data.
- `ack_i` in 1: slave acknowledge.
- `irq_i` in 1: DUT interrupt.

## Operation
- CMDR command codes: Start 0x04, Stop 0x05, Write 0x01, Read-with-NAK 0x03, Set Bus 0x06.
- CMDR status bits: bit 7 DON, bit 6 NAK, bit 5 AL, bit 4 ERR.
- States:
  - INIT: write CSR = 0xC0 (0x80 without IRQ, see Configuration).
  - IDLE
  - SETBUS: DPR = bus, then CMDR = 0x06, then WAIT.
  - START: CMDR = 0x04, then WAIT.
  - ADDR: DPR = {addr, ~we}, then CMDR = 0x01, then WAIT.
  - DATA: write path: DPR = data, CMDR = 0x01, then WAIT. Read path: CMDR = 0x03, then WAIT, then RDDPR (read DPR).
  - STOP: CMDR = 0x05, then WAIT.
  - RESP
- Bus cache:
  - The last successfully set bus is cached.
  - SETBUS is skipped when `req_bus` equals the cache and the cache is valid.
  - The cache is invalidated by reset, AL, or ERR.
- WAIT ends when CMDR reads back with any of DON/NAK/AL/ERR set. Outcomes:
  - DON: advance to the next state.
  - NAK on ADDR or write DATA: go to STOP, status 01.
  - AL: go straight to RESP, status 10, no stop issued.
  - ERR: go to STOP, status 11.
- Bad bus (`req_bus >= NUM_I2C_BUSSES`): no Wishbone traffic; RESP with status 11.
- After a completed STOP wait, RESP pulses `rsp_valid` and returns to IDLE.

## Timing
- Reset values: `cyc_o`, `stb_o`, `we_o` = 0; `adr_o`, `dat_o` = 0; `req_ready` = 0; `rsp_valid` = 0; `rsp_data` = 0; `rsp_status` = 00; FSM = INIT; bus cache invalid.
- `req_ready` = 1 only in IDLE. A request is accepted on the edge where `req_valid && req_ready`; request fields are registered at acceptance.
- Wishbone single access:
  - `cyc_o`, `stb_o`, `adr_o`, `we_o` and `dat_o` assert together and hold stable until `ack_i` is sampled high.
  - All drop the cycle after the ack.
  - At least one idle cycle separates accesses.
  - Read data is captured on the ack edge.
- `rsp_valid` is high for exactly one cycle. `rsp_data` and `rsp_status` hold until the next response.
- Reset asserted mid-operation: every output goes to its reset value on the next edge, including a Wishbone cycle in flight (it is abandoned). INIT reruns after reset drops.
- `irq_i` and `req_valid` arriving in the same cycle: no interaction; the request waits in IDLE.

## Configuration
- `I2CMB_SEQ_IRQ_EN` defined:
  - INIT writes CSR = 0xC0.
  - WAIT idles the Wishbone bus until `irq_i` = 1, then issues one CMDR read, which also clears the irq.
- Undefined:
  - INIT writes CSR = 0x80.
  - `irq_i` is ignored.
  - WAIT polls CMDR reads back-to-back (one idle cycle between them) until a status bit is set.

## Test plan
- After reset, write request bus 0, addr 0x22, data 0x5A → Wishbone writes in order: CSR 0xC0, DPR 0x00, CMDR 0x06, CMDR 0x04, DPR 0x44, CMDR 0x01, DPR 0x5A, CMDR 0x01, CMDR 0x05 (each followed by its status wait) → `rsp_status` = 00.
- Then read request, addr 0x22, with the slave returning 0xA5 → no SETBUS; DPR 0x45, CMDR 0x03, DPR read → `rsp_data` = 0xA5, status 00.
- No slave at addr 0x11 (NAK on address) → stop issued, no data phase, status 01; cache stays valid.
- Arbitration lost forced during the address phase → no stop issued, status 10; the next request re-issues Set Bus.
- Request with `req_bus` = 1 and `NUM_I2C_BUSSES` = 1 → zero Wishbone cycles; `rsp_valid` the cycle after acceptance with status 11.
- Reset asserted while waiting for an ack → `cyc_o`/`stb_o` = 0 on the next edge; after release the CSR write occurs before `req_ready` rises.
